// File: rtl/bcd_conv_pkg.sv
// Shared definitions for the digit-serial BCD code converter.
// Mode encodings, FSM states and the largest legal BCD digit.
package bcd_conv_pkg;

  localparam logic [1:0] MODE_XS3  = 2'd0;
  localparam logic [1:0] MODE_GRAY = 2'd1;
  localparam logic [1:0] MODE_2421 = 2'd2;
  localparam logic [1:0] MODE_BIN  = 2'd3;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_bad_digit(input logic [3:0] d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_encoder.sv
// Combinational single-digit encoder: BCD digit -> Excess-3 / Gray / 2421 nibble.
// Binary mode passes the digit through; the caller accumulates it.
module bcd_digit_encoder
  import bcd_conv_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic [1:0] i_mode,
  output logic [3:0] o_code,
  output logic       o_invalid
);

  always_comb begin
    o_code    = i_digit;
    o_invalid = is_bad_digit(i_digit);
    case (i_mode)
      MODE_XS3:  o_code = i_digit + 4'd3;
      MODE_GRAY: o_code = i_digit ^ (i_digit >> 1);
      MODE_2421: o_code = (i_digit >= 4'd5) ? i_digit + 4'd6 : i_digit;
      default:   o_code = i_digit;
    endcase
  end

endmodule

// File: rtl/bcd_code_converter.sv
// Digit-serial BCD word converter, MSD first, one digit per clock.
// Result appears DIGITS cycles after accept and is held until out_ready.
module bcd_code_converter
  import bcd_conv_pkg::*;
#(
  parameter  int DIGITS = 4,
  localparam int W      = 4 * DIGITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] bcd_in,
  input  logic [1:0]   mode_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] data_out,
  output logic         err
);

  localparam int              IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_MSD = IDX_W'(DIGITS - 1);

  state_t           r_state;
  logic [W-1:0]     r_bcd;
  logic [W-1:0]     r_acc;
  logic [1:0]       r_mode;
  logic [IDX_W-1:0] r_idx;
  logic             r_err;

  logic [3:0]       w_digit;
  logic [3:0]       w_code;
  logic             w_invalid;
  logic [W-1:0]     w_acc_next;
  logic             w_err_next;

  assign w_digit = r_bcd[{r_idx, 2'b00} +: 4];

  bcd_digit_encoder u_enc (
    .i_digit   (w_digit),
    .i_mode    (r_mode),
    .o_code    (w_code),
    .o_invalid (w_invalid)
  );

  // Binary mode is a running acc*10+d; code modes drop the nibble in place.
  always_comb begin
    w_acc_next = r_acc;
    if (r_mode == MODE_BIN) begin
      w_acc_next = (r_acc << 3) + (r_acc << 1) + W'(w_digit);
    end else begin
      w_acc_next[{r_idx, 2'b00} +: 4] = w_code;
    end
    w_err_next = r_err | w_invalid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bcd     <= '0;
      r_acc     <= '0;
      r_mode    <= MODE_XS3;
      r_idx     <= '0;
      r_err     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      data_out  <= '0;
      err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            r_bcd    <= bcd_in;
            r_mode   <= mode_in;
            r_acc    <= '0;
            r_err    <= 1'b0;
            r_idx    <= IDX_MSD;
            in_ready <= 1'b0;
            r_state  <= CONV;
          end
        end
        CONV: begin
          r_acc <= w_acc_next;
          r_err <= w_err_next;
          if (r_idx == '0) begin
            data_out  <= w_err_next ? '1 : w_acc_next;
            err       <= w_err_next;
            out_valid <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        DONE: begin
          // in_ready comes back with the retiring edge, so nothing is taken this cycle.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_code_converter.sv
// Self-checking bench: directed table, randomized words against a table-based model,
// backpressure and mid-conversion reset.
module tb_bcd_code_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bcd_in;
  logic [1:0]  mode_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] data_out;
  logic        err;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  bcd_code_converter #(.DIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .mode_in   (mode_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .err       (err)
  );

  int xs3_t  [10] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
  int gray_t [10] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13};
  int aik_t  [10] = '{0, 1, 2, 3, 4, 11, 12, 13, 14, 15};

  typedef struct {
    logic [15:0] bcd;
    logic [1:0]  mode;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: digit tables for code modes, decimal arithmetic for binary.
  task automatic model(input logic [15:0] b, input logic [1:0] m,
                       output logic [15:0] d, output logic e);
    int val = 0;
    int dig;
    d = '0;
    e = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      dig = int'((b >> (4 * i)) & 16'hF);
      if (dig > 9) e = 1'b1;
      else begin
        case (m)
          2'd0: d = d | (16'(xs3_t[dig]) << (4 * i));
          2'd1: d = d | (16'(gray_t[dig]) << (4 * i));
          2'd2: d = d | (16'(aik_t[dig]) << (4 * i));
          default: val = val * 10 + dig;
        endcase
      end
    end
    if (m == 2'd3) d = 16'(val);
    if (e) d = 16'hFFFF;
  endtask

  task automatic run_word(input logic [15:0] b, input logic [1:0] m, input int hold,
                          output logic [15:0] d, output logic e, output int lat);
    int n = 0;
    logic [15:0] held;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    bcd_in   = b;
    mode_in  = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    bcd_in   = 16'($urandom);
    mode_in  = 2'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("out_valid_wait", {31'd0, out_valid}, 32'd1);
    d    = data_out;
    e    = err;
    held = data_out;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check("hold_data", {16'd0, data_out}, {16'd0, held});
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("retire_valid", {31'd0, out_valid}, 32'd0);
    check("retire_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [15:0] got_d, exp_d, b;
    logic        got_e, exp_e;
    int          lat;

    vecs[0] = '{16'h0129, 2'd0, 16'h345C, 1'b0};
    vecs[1] = '{16'h9876, 2'd1, 16'hDC45, 1'b0};
    vecs[2] = '{16'h5049, 2'd2, 16'hB04F, 1'b0};
    vecs[3] = '{16'h9999, 2'd3, 16'h270F, 1'b0};
    vecs[4] = '{16'h0000, 2'd3, 16'h0000, 1'b0};
    vecs[5] = '{16'h12A4, 2'd0, 16'hFFFF, 1'b1};
    vecs[6] = '{16'h0000, 2'd0, 16'h3333, 1'b0};
    vecs[7] = '{16'h12A4, 2'd3, 16'hFFFF, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; bcd_in = '0; mode_in = '0;
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data_out", {16'd0, data_out}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_word(vecs[i].bcd, vecs[i].mode, 0, got_d, got_e, lat);
      check($sformatf("vec%0d_data", i), {16'd0, got_d}, {16'd0, vecs[i].exp_data});
      check($sformatf("vec%0d_err", i), {31'd0, got_e}, {31'd0, vecs[i].exp_err});
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
    end

    // Backpressure: result and flags frozen for 5 cycles with out_ready low.
    run_word(16'h0129, 2'd0, 5, got_d, got_e, lat);
    check("bp_data", {16'd0, got_d}, 32'h345C);

    for (int r = 0; r < 40; r++) begin
      b = '0;
      for (int k = 0; k < 4; k++)
        b[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                 : 4'($urandom_range(0, 9));
      model(b, 2'($urandom_range(0, 3)), exp_d, exp_e);
      mode_in = 2'd0;
    end

    for (int r = 0; r < 40; r++) begin
      logic [1:0] m;
      b = '0;
      for (int k = 0; k < 4; k++)
        b[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                 : 4'($urandom_range(0, 9));
      m = 2'($urandom_range(0, 3));
      model(b, m, exp_d, exp_e);
      run_word(b, m, $urandom_range(0, 2), got_d, got_e, lat);
      check($sformatf("rnd%0d_data b=%h m=%0d", r, b, m), {16'd0, got_d}, {16'd0, exp_d});
      check($sformatf("rnd%0d_err", r), {31'd0, got_e}, {31'd0, exp_e});
      check($sformatf("rnd%0d_latency", r), 32'(lat), 32'd4);
    end

    // Reset two cycles into CONV: outputs return to reset values without a clock.
    @(negedge clk);
    bcd_in = 16'h4321; mode_in = 2'd1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data_out", {16'd0, data_out}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      check("mid_rst_no_output", {31'd0, out_valid}, 32'd0);
    end
    run_word(16'h0729, 2'd3, 0, got_d, got_e, lat);
    check("post_rst_data", {16'd0, got_d}, 32'h02D9);
    check("post_rst_err", {31'd0, got_e}, 32'd0);
    check("post_rst_latency", 32'(lat), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
